// File: rtl/vdp_timing_pkg.sv
// Shared raster timing constants and helpers for the VDP sync path.
package vdp_timing_pkg;

    typedef enum logic {
        MODE_60HZ = 1'b0,
        MODE_50HZ = 1'b1
    } vmode_e;

    localparam logic [10:0] H_TOTAL      = 11'd1368;
    localparam logic [10:0] HSYNC_WIDTH  = 11'd100;
    localparam logic [10:0] H_HALF       = 11'd684;
    localparam logic [9:0]  VSYNC_START  = 10'd3;
    localparam logic [9:0]  VSYNC_END    = 10'd6;
    localparam logic [9:0]  VINT_LINE_60 = 10'd234;
    localparam logic [9:0]  VINT_LINE_50 = 10'd259;
    localparam logic [9:0]  V_TOTAL_60   = 10'd262;
    localparam logic [9:0]  V_TOTAL_50   = 10'd313;

    function automatic logic [9:0] v_total(input vmode_e mode);
        return (mode == MODE_50HZ) ? V_TOTAL_50 : V_TOTAL_60;
    endfunction

    function automatic logic [9:0] vint_line(input vmode_e mode);
        return (mode == MODE_50HZ) ? VINT_LINE_50 : VINT_LINE_60;
    endfunction

endpackage

// File: rtl/vdp_sync_generator_if.sv
// Raster position / register inputs and sync outputs of the VDP sync generator.
interface vdp_sync_generator_if;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        screen_active;
    logic        reg_50hz_mode;
    logic        reg_interlace_mode;
    logic        reg_int_enable;
    logic        status_read;
    logic        hsync_n;
    logic        vsync_n;
    logic        csync_n;
    logic        blank;
    logic        field_odd;
    logic        vint_flag;
    logic        int_n;

    modport master (
        output h_count, v_count, screen_active, reg_50hz_mode,
               reg_interlace_mode, reg_int_enable, status_read,
        input  hsync_n, vsync_n, csync_n, blank, field_odd, vint_flag, int_n
    );

    modport slave (
        input  h_count, v_count, screen_active, reg_50hz_mode,
               reg_interlace_mode, reg_int_enable, status_read,
        output hsync_n, vsync_n, csync_n, blank, field_odd, vint_flag, int_n
    );
endinterface

// File: rtl/vdp_vint_flag.sv
// Vertical interrupt flag (S#0 bit 7) and the CPU interrupt request derived from it.
module vdp_vint_flag (
    input  logic clk,
    input  logic reset,
    input  logic set_evt,
    input  logic clear,
    input  logic int_enable,
    output logic vint_flag,
    output logic int_n
);

    always_ff @(posedge clk) begin
        if (reset) begin
            vint_flag <= 1'b0;
            int_n     <= 1'b1;
        end else begin
            // A status read landing on the set cycle must not lose the interrupt.
            if (set_evt)
                vint_flag <= 1'b1;
            else if (clear)
                vint_flag <= 1'b0;
            int_n <= ~(vint_flag & int_enable);
        end
    end

endmodule

// File: rtl/vdp_sync_generator.sv
// Registered horizontal/vertical/composite sync, blanking, field and vertical interrupt.
module vdp_sync_generator
    import vdp_timing_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    vdp_sync_generator_if.slave  bus
);

    vmode_e mode;
    logic   in_frame;
    logic   vwin;
    logic   hsync_next;
    logic   vint_set;

    logic   hsync_q;
    logic   vsync_q;
    logic   csync_q;
    logic   blank_q;
    logic   field_q;

    assign mode = bus.reg_50hz_mode ? MODE_50HZ : MODE_60HZ;

    always_comb begin
        in_frame   = (bus.v_count < v_total(mode)) && (bus.h_count < H_TOTAL);
        hsync_next = (bus.h_count >= HSYNC_WIDTH);
        vint_set   = in_frame && (bus.h_count == 11'd0) && (bus.v_count == vint_line(mode));
        vwin       = 1'b0;
        if (in_frame) begin
            // Odd fields start and end vertical sync half a line late.
            if (field_q)
                vwin = ((bus.v_count == VSYNC_START) && (bus.h_count >= H_HALF)) ||
                       ((bus.v_count > VSYNC_START) && (bus.v_count < VSYNC_END)) ||
                       ((bus.v_count == VSYNC_END) && (bus.h_count < H_HALF));
            else
                vwin = (bus.v_count >= VSYNC_START) && (bus.v_count < VSYNC_END);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            csync_q <= 1'b1;
            blank_q <= 1'b1;
            field_q <= 1'b0;
        end else begin
            hsync_q <= hsync_next;
            vsync_q <= ~vwin;
            csync_q <= vwin ? ~hsync_next : hsync_next;
            blank_q <= ~bus.screen_active;
            if (!bus.reg_interlace_mode)
                field_q <= 1'b0;
            else if ((bus.v_count == 10'd0) && (bus.h_count == 11'd0))
                field_q <= ~field_q;
        end
    end

    vdp_vint_flag u_vint_flag (
        .clk        (clk),
        .reset      (reset),
        .set_evt    (vint_set),
        .clear      (bus.status_read),
        .int_enable (bus.reg_int_enable),
        .vint_flag  (bus.vint_flag),
        .int_n      (bus.int_n)
    );

    assign bus.hsync_n   = hsync_q;
    assign bus.vsync_n   = vsync_q;
    assign bus.csync_n   = csync_q;
    assign bus.blank     = blank_q;
    assign bus.field_odd = field_q;

endmodule

// File: tb/tb_vdp_sync_generator.sv
// Directed-vector bench for vdp_sync_generator with hand-computed expectations.
module tb_vdp_sync_generator;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    vdp_sync_generator_if bus();

    vdp_sync_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present (v,h) for one clock; outputs are examined 1 ns after that edge.
    task automatic apply(input logic [9:0] v, input logic [10:0] h);
        bus.v_count = v;
        bus.h_count = h;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync"}, bus.hsync_n, 1);
        chk({tag, "_vsync"}, bus.vsync_n, 1);
        chk({tag, "_csync"}, bus.csync_n, 1);
        chk({tag, "_blank"}, bus.blank, 1);
        chk({tag, "_field"}, bus.field_odd, 0);
        chk({tag, "_vint"},  bus.vint_flag, 0);
        chk({tag, "_int_n"}, bus.int_n, 1);
    endtask

    initial begin
        int hs_low, vs_low, cs_low, fo_high;
        n_checks = 0;
        n_fail   = 0;
        bus.h_count            = '0;
        bus.v_count            = '0;
        bus.screen_active      = 1'b0;
        bus.reg_50hz_mode      = 1'b0;
        bus.reg_interlace_mode = 1'b0;
        bus.reg_int_enable     = 1'b0;
        bus.status_read        = 1'b0;
        reset                  = 1'b1;
        @(posedge clk);
        #1;
        apply(10'd0, 11'd0);
        chk_reset_vals("rst");
        reset = 1'b0;

        // 60 Hz non-interlace: lines 0..7 of two frames.
        hs_low = 0; vs_low = 0; cs_low = 0; fo_high = 0;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < 8; v++) begin
                for (int h = 0; h < 1368; h++) begin
                    apply(v[9:0], h[10:0]);
                    if (!bus.hsync_n) hs_low++;
                    if (!bus.vsync_n) vs_low++;
                    if (!bus.csync_n) cs_low++;
                    if (bus.field_odd) fo_high++;
                    if (v == 2 && h == 1367) chk("vs_before_start", bus.vsync_n, 1);
                    if (v == 3 && h == 0)    chk("vs_at_start", bus.vsync_n, 0);
                    if (v == 5 && h == 1367) chk("vs_last", bus.vsync_n, 0);
                    if (v == 6 && h == 0)    chk("vs_at_end", bus.vsync_n, 1);
                    if (v == 4 && h == 99)   chk("cs_in_win_hs", bus.csync_n, 1);
                    if (v == 4 && h == 100)  chk("cs_in_win_act", bus.csync_n, 0);
                end
            end
        end
        chk("hs_low_count", hs_low, 1600);
        chk("vs_low_count", vs_low, 8208);
        chk("cs_low_count", cs_low, 8608);
        chk("field_high_count", fo_high, 0);

        bus.screen_active = 1'b1;
        apply(10'd10, 11'd200);
        chk("blank_active", bus.blank, 0);
        chk("hsync_high", bus.hsync_n, 1);
        bus.screen_active = 1'b0;
        apply(10'd10, 11'd50);
        chk("blank_inactive", bus.blank, 1);
        chk("hsync_low", bus.hsync_n, 0);

        // Interlace: odd field shifts the vertical window by half a line.
        bus.reg_interlace_mode = 1'b1;
        apply(10'd0, 11'd0);
        chk("field_toggle1", bus.field_odd, 1);
        apply(10'd3, 11'd683);
        chk("odd_vs_pre", bus.vsync_n, 1);
        apply(10'd3, 11'd684);
        chk("odd_vs_start", bus.vsync_n, 0);
        chk("odd_cs_start", bus.csync_n, 0);
        apply(10'd6, 11'd683);
        chk("odd_vs_last", bus.vsync_n, 0);
        apply(10'd6, 11'd684);
        chk("odd_vs_end", bus.vsync_n, 1);
        apply(10'd0, 11'd0);
        chk("field_toggle2", bus.field_odd, 0);
        apply(10'd3, 11'd0);
        chk("even_vs_start", bus.vsync_n, 0);
        apply(10'd0, 11'd0);
        chk("field_toggle3", bus.field_odd, 1);
        bus.reg_interlace_mode = 1'b0;
        apply(10'd1, 11'd0);
        chk("field_forced0", bus.field_odd, 0);

        // 50 Hz vertical interrupt.
        bus.reg_50hz_mode  = 1'b1;
        bus.reg_int_enable = 1'b1;
        apply(10'd234, 11'd0);
        chk("no_vint_60line_in_50", bus.vint_flag, 0);
        apply(10'd259, 11'd0);
        chk("vint50_set", bus.vint_flag, 1);
        chk("int_n_lag", bus.int_n, 1);
        apply(10'd259, 11'd1);
        chk("int_n_asserted", bus.int_n, 0);
        bus.status_read = 1'b1;
        apply(10'd260, 11'd10);
        bus.status_read = 1'b0;
        chk("vint_cleared", bus.vint_flag, 0);
        chk("int_n_still_low", bus.int_n, 0);
        apply(10'd260, 11'd11);
        chk("int_n_released", bus.int_n, 1);

        // 60 Hz: 50 Hz line is not an event; set wins over a coincident read.
        bus.reg_50hz_mode = 1'b0;
        apply(10'd259, 11'd0);
        chk("no_vint_50line_in_60", bus.vint_flag, 0);
        apply(10'd300, 11'd0);
        chk("no_vint_beyond_frame", bus.vint_flag, 0);
        bus.status_read = 1'b1;
        apply(10'd234, 11'd0);
        bus.status_read = 1'b0;
        chk("set_wins", bus.vint_flag, 1);

        bus.reg_int_enable = 1'b0;
        apply(10'd234, 11'd5);
        chk("ie_off_int_n", bus.int_n, 1);
        chk("ie_off_flag", bus.vint_flag, 1);
        bus.reg_int_enable = 1'b1;
        apply(10'd234, 11'd6);
        chk("ie_on_int_n", bus.int_n, 0);
        chk("ie_on_flag", bus.vint_flag, 1);

        // Mid-frame reset inside the vsync window, then a reset coinciding with a set event.
        bus.reg_interlace_mode = 1'b1;
        apply(10'd0, 11'd0);
        chk("pre_reset_field", bus.field_odd, 1);
        reset = 1'b1;
        bus.screen_active = 1'b1;
        apply(10'd4, 11'd500);
        chk_reset_vals("midrst");
        apply(10'd234, 11'd0);
        chk("rst_beats_set", bus.vint_flag, 0);
        reset = 1'b0;
        apply(10'd4, 11'd501);
        chk("resume_vsync", bus.vsync_n, 0);
        chk("resume_hsync", bus.hsync_n, 1);
        chk("resume_csync", bus.csync_n, 0);
        chk("resume_blank", bus.blank, 0);
        chk("resume_field", bus.field_odd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
